int_writeback: RTL and testbench

Writeback stage for the integer pipeline: merges results from the single-cycle ALU path and the long-latency load/multiply path onto the single write port of the integer register file. It registers the winning result for one cycle and forwards it to the operand read ports, so reads stay correct while the register file write is still pending. It also keeps a busy scoreboard of destinations owed by the long-latency path, which the issue stage uses to stall.

---
 rtl/int_writeback.sv | 126 ++++++++++++
 tb/tb_int_writeback.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_writeback.sv
// Integer writeback: arbitrates ALU and long-latency results onto the single RF write port and forwards W to operand reads.
// Latency: a result accepted at edge N is presented on rf_* during cycle N+1; busy bits update at the accepting edge.
// Backpressure: the ALU wins by default; a long-latency result stalled for STARVE_LIMIT cycles takes priority for one cycle.
module int_writeback #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        rf_wen,
    output logic [4:0]  rf_rd_addr,
    output logic [31:0] rf_wdata,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_rf_data,
    input  logic [31:0] rs2_rf_data,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic        rs1_busy,
    output logic        rs2_busy
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef struct packed {
        logic        vld;
        logic [4:0]  rd;
        logic [31:0] dat;
    } wb_t;

    wb_t         w_q;
    wb_t         w_d;
    logic [3:0]  starve_cnt;
    logic [31:1] busy_q;
    logic [31:1] busy_d;
    logic [31:0] busy_vec;
    logic        lsu_prio;
    logic        alu_fire;
    logic        lsu_fire;

    assign lsu_prio = (starve_cnt == LIMIT);

    always_comb begin
        alu_ready = 1'b1;
        lsu_ready = !alu_valid;
        if (lsu_prio) begin
            lsu_ready = 1'b1;
            alu_ready = !lsu_valid;
        end
    end

    // Ready terms are mutually exclusive whenever both valids are high, so at most one fires.
    assign alu_fire = alu_valid && alu_ready;
    assign lsu_fire = lsu_valid && lsu_ready;

    always_comb begin
        w_d     = w_q;
        w_d.vld = 1'b0;
        if (lsu_fire && lsu_rd != 5'd0) begin
            w_d = '{vld: 1'b1, rd: lsu_rd, dat: lsu_data};
        end else if (alu_fire && alu_rd != 5'd0) begin
            w_d = '{vld: 1'b1, rd: alu_rd, dat: alu_data};
        end
    end

    // A set and a clear of the same register in one cycle resolve to busy.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < 32; i++) begin
            busy_d[i] = (busy_q[i] && !(lsu_fire && lsu_rd == 5'(i)))
                      || (issue_valid && issue_rd == 5'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_q        <= '0;
            busy_q     <= '0;
            starve_cnt <= '0;
        end else begin
            w_q    <= w_d;
            busy_q <= busy_d;
            if (lsu_valid && !lsu_ready) begin
                starve_cnt <= lsu_prio ? LIMIT : starve_cnt + 4'd1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    assign rf_wen     = w_q.vld;
    assign rf_rd_addr = w_q.rd;
    assign rf_wdata   = w_q.dat;

    assign busy_vec = {busy_q, 1'b0};
    assign rs1_busy = busy_vec[rs1_addr];
    assign rs2_busy = busy_vec[rs2_addr];

    always_comb begin
        rs1_data = rs1_rf_data;
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end else if (w_q.vld && w_q.rd == rs1_addr) begin
            rs1_data = w_q.dat;
        end
    end

    always_comb begin
        rs2_data = rs2_rf_data;
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end else if (w_q.vld && w_q.rd == rs2_addr) begin
            rs2_data = w_q.dat;
        end
    end

endmodule

// File: tb/tb_int_writeback.sv
// Directed bench for int_writeback: expected RF writes go into a queue checked by a monitor; other outputs checked inline.
module tb_int_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_wen;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rf_data;
    logic [31:0] rs2_rf_data;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;

    always #5 clk = ~clk;

    int_writeback #(.STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .rf_wen      (rf_wen),
        .rf_rd_addr  (rf_rd_addr),
        .rf_wdata    (rf_wdata),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_rf_data (rs1_rf_data),
        .rs2_rf_data (rs2_rf_data),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy)
    );

    logic [36:0] exp_q[$];
    logic [36:0] mon_e;
    logic [31:0] busy_mask;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every RF write must match the oldest expected write.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (rf_wen !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: got rd=%0d data=0x%08h expected no write",
                             rf_rd_addr, rf_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rf_write", {27'd0, rf_wen, rf_rd_addr, rf_wdata}, {27'd0, 1'b1, mon_e});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        issue_valid = 1'b0; issue_rd = '0;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hAAAA_0005;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        rs1_addr = '0; rs2_addr = '0; rs1_rf_data = '0; rs2_rf_data = '0;

        // Reset held two cycles with an ALU result present
        @(negedge clk);
        check("alu_ready_in_reset", alu_ready, 1);
        cyc(); cyc();
        reset = 1'b0; alu_valid = 1'b0;
        @(negedge clk);
        check("rf_wen_after_reset", rf_wen, 0);
        busy_mask = '0;
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a); rs2_addr = 5'(31 - a);
            #1;
            busy_mask[a] = rs1_busy | rs2_busy;
        end
        check("busy_after_reset", busy_mask, 0);

        // ALU write and forward
        cyc();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEAD_BEEF;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        exp_q.push_back({5'd3, 32'hDEAD_BEEF});
        @(negedge clk);
        check("alu_ready_normal", alu_ready, 1);
        cyc();
        alu_valid = 1'b0; rs1_addr = 5'd3; rs1_rf_data = 32'd0;
        @(negedge clk);
        check("rf_wen_alu", rf_wen, 1);
        check("rs1_forward", rs1_data, 32'hDEAD_BEEF);
        cyc();
        rs1_rf_data = 32'h1111_1111;
        @(negedge clk);
        check("rs1_rf_passthrough", rs1_data, 32'h1111_1111);

        // x0 writes complete but never land; x0 reads as zero
        cyc();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
        rs2_addr = 5'd0; rs2_rf_data = 32'hFFFF_FFFF;
        @(negedge clk);
        check("x0_alu_ready", alu_ready, 1);
        check("x0_read_zero", rs2_data, 0);
        cyc();
        alu_valid = 1'b0;
        @(negedge clk);
        check("x0_no_write", rf_wen, 0);

        // Scoreboard set then clear with forwarding
        cyc();
        issue_valid = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7;
        @(negedge clk);
        check("busy7_before_issue", rs1_busy, 0);
        cyc();
        issue_valid = 1'b0;
        @(negedge clk);
        check("busy7_set", rs1_busy, 1);
        cyc();
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h55;
        exp_q.push_back({5'd7, 32'h55});
        @(negedge clk);
        check("lsu_ready_idle_alu", lsu_ready, 1);
        cyc();
        lsu_valid = 1'b0; rs1_rf_data = 32'd0;
        @(negedge clk);
        check("busy7_cleared", rs1_busy, 0);
        check("rs1_forward_lsu", rs1_data, 32'h55);

        // Back-to-back writes to one register
        cyc();
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA1;
        rs2_addr = 5'd10; rs2_rf_data = 32'd0;
        exp_q.push_back({5'd10, 32'hA1});
        cyc();
        alu_data = 32'hA2;
        exp_q.push_back({5'd10, 32'hA2});
        @(negedge clk);
        check("b2b_first", rs2_data, 32'hA1);
        cyc();
        alu_valid = 1'b0;
        @(negedge clk);
        check("b2b_newest", rs2_data, 32'hA2);

        // Starvation: ALU and LSU both valid
        cyc();
        issue_valid = 1'b1; issue_rd = 5'd12;
        cyc();
        issue_rd = 5'd14;
        cyc();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd13;
        lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'hCAFE;
        for (int i = 0; i < 4; i++) begin
            alu_data = 32'h100 + 32'(i);
            exp_q.push_back({5'd13, 32'h100 + 32'(i)});
            @(negedge clk);
            check("starve_lsu_wait", lsu_ready, 0);
            check("starve_alu_wins", alu_ready, 1);
            cyc();
        end
        exp_q.push_back({5'd12, 32'hCAFE});
        @(negedge clk);
        check("starve_flip_lsu", lsu_ready, 1);
        check("starve_flip_alu", alu_ready, 0);
        cyc();
        lsu_rd = 5'd14; lsu_data = 32'hBEEF; alu_data = 32'h200;
        exp_q.push_back({5'd13, 32'h200});
        @(negedge clk);
        check("starve_cleared_alu", alu_ready, 1);
        check("starve_cleared_lsu", lsu_ready, 0);
        cyc();
        alu_valid = 1'b0;
        exp_q.push_back({5'd14, 32'hBEEF});
        @(negedge clk);
        check("lsu_after_alu_idle", lsu_ready, 1);

        // Simultaneous set and clear of one register
        cyc();
        lsu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd9;
        cyc();
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
        rs2_addr = 5'd9; rs2_rf_data = 32'd0;
        exp_q.push_back({5'd9, 32'h99});
        @(negedge clk);
        check("busy9_set", rs2_busy, 1);
        cyc();
        issue_valid = 1'b0; lsu_valid = 1'b0;
        @(negedge clk);
        check("busy9_set_wins", rs2_busy, 1);
        cyc();
        lsu_valid = 1'b1; lsu_data = 32'h9A;
        exp_q.push_back({5'd9, 32'h9A});
        cyc();
        lsu_valid = 1'b0;
        @(negedge clk);
        check("busy9_cleared", rs2_busy, 0);
        check("rs2_forward_9", rs2_data, 32'h9A);

        // Reset mid-operation
        cyc();
        issue_valid = 1'b1; issue_rd = 5'd22;
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h20;
        exp_q.push_back({5'd20, 32'h20});
        cyc();
        issue_valid = 1'b0; reset = 1'b1;
        alu_rd = 5'd21; alu_data = 32'h21;
        @(negedge clk);
        check("alu_ready_mid_reset", alu_ready, 1);
        cyc();
        reset = 1'b0; alu_valid = 1'b0;
        rs1_addr = 5'd22; rs2_addr = 5'd21; rs2_rf_data = 32'd0;
        @(negedge clk);
        check("rf_wen_after_mid_reset", rf_wen, 0);
        check("busy22_reset", rs1_busy, 0);
        check("discarded_write", rs2_data, 0);

        cyc(); cyc();
        @(negedge clk);
        check("expected_writes_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
